// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared defaults, tag type and round-robin index helpers
package mul_arb_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int MAX_REQ = 8;
    typedef logic [$clog2(MAX_REQ)-1:0] tagT;
    function automatic tagT rrNext(input tagT g, input int n);
        return (int'(g) + 1 >= n) ? '0 : tagT'(int'(g) + 1);
    endfunction
    function automatic tagT rrIdx(input tagT base, input int k, input int n);
        int j;
        j = int'(base) + k;
        return tagT'((j >= n) ? j - n : j);
    endfunction
endpackage

// File: rtl/mul_tag_fifo.sv
// mul_tag_fifo: in-order requester tag FIFO with occupancy count
module mul_tag_fifo
    import mul_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  tagT                    din,
    output tagT                    dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    tagT mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic doPush, doPop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign doPush = push & ~full;
    assign doPop = pop & ~empty;
    assign dout = mem[rdPtr];
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop) rdPtr <= rdPtr + 1'b1;
            count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
    always_ff @(posedge clk)
        if (doPush) mem[wrPtr] <= din;
endmodule

// File: rtl/mul_stage_arbiter.sv
// mul_stage_arbiter: round-robin sharing of one pipelined multiplier with in-order result steering
module mul_stage_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = DATA_W_DEF,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]     req_a,
    input  logic [NUM_REQ*DATA_W-1:0]     req_b,
    output logic [NUM_REQ-1:0]            resp_valid,
    input  logic [NUM_REQ-1:0]            resp_ready,
    output logic [DATA_W-1:0]             resp_data,
    output logic                          mul_srcReady,
    input  logic                          mul_readyForInput,
    output logic [DATA_W-1:0]             mul_in_A,
    output logic [DATA_W-1:0]             mul_in_B,
    input  logic                          mul_outputReady,
    output logic                          mul_destReady,
    input  logic [DATA_W-1:0]             mul_result,
    output logic [$clog2(MAX_INFLIGHT):0] inflight,
    output logic                          err_orphan
);
    logic full, issue, canLoad, found, reqFire, fifoFull, fifoEmpty;
    tagT rrPtr, win, regTag, headTag;
    logic [DATA_W-1:0] regA, regB;
    logic [NUM_REQ-1:0] winHot, headHot;
    always_comb begin
        found = 1'b0;
        win = '0;
        for (int k = 0; k < NUM_REQ; k++)
            for (int i = 0; i < NUM_REQ; i++)
                if (!found && req_valid[i] && tagT'(i) == rrIdx(rrPtr, k, NUM_REQ)) begin
                    found = 1'b1;
                    win = tagT'(i);
                end
    end
    always_comb begin
        winHot = '0;
        headHot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            winHot[i] = win == tagT'(i);
            headHot[i] = headTag == tagT'(i);
        end
    end
    assign mul_srcReady = full & ~fifoFull;
    assign issue = mul_srcReady & mul_readyForInput;
    // rst gates the grant so req_ready drops the moment reset asserts
    assign canLoad = rst & (~full | issue);
    assign reqFire = found & canLoad;
    assign req_ready = reqFire ? winHot : '0;
    assign resp_valid = (mul_outputReady & ~fifoEmpty) ? headHot : '0;
    assign resp_data = mul_result;
    assign mul_destReady = fifoEmpty ? mul_outputReady : |(resp_ready & headHot);
    assign mul_in_A = regA;
    assign mul_in_B = regB;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            full <= 1'b0;
            rrPtr <= '0;
            regA <= '0;
            regB <= '0;
            regTag <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (reqFire) begin
                full <= 1'b1;
                regA <= req_a[int'(win)*DATA_W +: DATA_W];
                regB <= req_b[int'(win)*DATA_W +: DATA_W];
                regTag <= win;
                rrPtr <= rrNext(win, NUM_REQ);
            end else if (issue) begin
                full <= 1'b0;
            end
            if (mul_outputReady & fifoEmpty) err_orphan <= 1'b1;
        end
    mul_tag_fifo #(.DEPTH(MAX_INFLIGHT)) tagFifo (
        .clk(clk),
        .rst(rst),
        .push(issue),
        .pop(mul_outputReady & mul_destReady),
        .din(regTag),
        .dout(headTag),
        .count(inflight),
        .full(fifoFull),
        .empty(fifoEmpty)
    );
endmodule

// File: tb/tb_mul_stage_arbiter.sv
// tb_mul_stage_arbiter: directed checks of arbitration, backpressure, FIFO limit, reset and stalls
module tb_mul_stage_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] req_valid, req_ready, resp_valid, resp_ready;
    logic [63:0] req_a, req_b;
    logic [15:0] resp_data, mul_in_A, mul_in_B, mul_result;
    logic mul_srcReady, mul_readyForInput, mul_outputReady, mul_destReady, err_orphan;
    logic [2:0] inflight;
    int tests = 0;
    int fails = 0;

    mul_stage_arbiter #(.NUM_REQ(4), .DATA_W(16), .MAX_INFLIGHT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .mul_srcReady(mul_srcReady), .mul_readyForInput(mul_readyForInput),
        .mul_in_A(mul_in_A), .mul_in_B(mul_in_B),
        .mul_outputReady(mul_outputReady), .mul_destReady(mul_destReady),
        .mul_result(mul_result), .inflight(inflight), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        req_valid = '0;
        resp_ready = '0;
        mul_readyForInput = 1'b0;
        mul_outputReady = 1'b0;
        mul_result = '0;
        for (int i = 0; i < 4; i++) begin
            req_a[i*16 +: 16] = 16'h10 + 16'(i);
            req_b[i*16 +: 16] = 16'h20 + 16'(i);
        end
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_srcReady", 32'(mul_srcReady), 32'h0);
        chk("rst_destReady", 32'(mul_destReady), 32'h0);
        chk("rst_inflight", 32'(inflight), 32'h0);
        chk("rst_err", 32'(err_orphan), 32'h0);
        tick();
        tick();
        rst = 1'b1;

        // single requester
        req_a[31:16] = 16'h3C00;
        req_b[31:16] = 16'h4000;
        req_valid = 4'b0010;
        #1 chk("t1_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        chk("t1_srcReady", 32'(mul_srcReady), 32'h1);
        chk("t1_inA", 32'(mul_in_A), 32'h3C00);
        chk("t1_inB", 32'(mul_in_B), 32'h4000);
        mul_readyForInput = 1'b1;
        tick();
        chk("t1_srcDone", 32'(mul_srcReady), 32'h0);
        chk("t1_inflight1", 32'(inflight), 32'h1);
        mul_outputReady = 1'b1;
        mul_result = 16'h4000;
        resp_ready = 4'b0010;
        #1 chk("t1_resp_valid", 32'(resp_valid), 32'h2);
        chk("t1_resp_data", 32'(resp_data), 32'h4000);
        chk("t1_destReady", 32'(mul_destReady), 32'h1);
        tick();
        mul_outputReady = 1'b0;
        chk("t1_inflight0", 32'(inflight), 32'h0);
        req_a[31:16] = 16'h11;
        req_b[31:16] = 16'h21;

        // round robin from a fresh pointer
        rst = 1'b0;
        #1 rst = 1'b1;
        req_valid = 4'hF;
        resp_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #1 chk("t2_grant", 32'(req_ready), 32'(1 << k));
            if (k > 0) chk("t2_inA", 32'(mul_in_A), 32'h10 + 32'(k - 1));
            tick();
        end
        req_valid = '0;
        chk("t2_inA3", 32'(mul_in_A), 32'h13);
        tick();
        chk("t2_inflight4", 32'(inflight), 32'h4);
        for (int k = 0; k < 4; k++) begin
            mul_outputReady = 1'b1;
            mul_result = 16'h100 + 16'(k);
            #1 chk("t2_resp_valid", 32'(resp_valid), 32'(1 << k));
            chk("t2_resp_data", 32'(resp_data), 32'h100 + 32'(k));
            tick();
        end
        mul_outputReady = 1'b0;
        chk("t2_inflight0", 32'(inflight), 32'h0);

        // backpressure from the multiplier
        mul_readyForInput = 1'b0;
        req_valid = 4'b0001;
        #1 chk("t3_grant0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            #1 chk("t3_no_ready", 32'(req_ready), 32'h0);
            chk("t3_stableA", 32'(mul_in_A), 32'h10);
            chk("t3_stableB", 32'(mul_in_B), 32'h20);
            chk("t3_srcReady", 32'(mul_srcReady), 32'h1);
            chk("t3_inflight", 32'(inflight), 32'h0);
            tick();
        end
        mul_readyForInput = 1'b1;
        #1 chk("t3_grant2", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        chk("t3_inflight1", 32'(inflight), 32'h1);
        chk("t3_inA2", 32'(mul_in_A), 32'h12);
        tick();
        mul_outputReady = 1'b1;
        mul_result = 16'h200;
        #1 chk("t3_resp0", 32'(resp_valid), 32'h1);
        tick();
        mul_result = 16'h202;
        #1 chk("t3_resp2", 32'(resp_valid), 32'h4);
        chk("t3_data2", 32'(resp_data), 32'h202);
        tick();
        mul_outputReady = 1'b0;
        chk("t3_inflight0", 32'(inflight), 32'h0);

        // tag FIFO fills while responses are blocked
        resp_ready = '0;
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) tick();
        chk("t4_inflight4", 32'(inflight), 32'h4);
        chk("t4_srcReady0", 32'(mul_srcReady), 32'h0);
        chk("t4_no_ready", 32'(req_ready), 32'h0);
        req_valid = '0;
        mul_outputReady = 1'b1;
        mul_result = 16'h300;
        #1 chk("t4_head3", 32'(resp_valid), 32'h8);
        chk("t4_dest0", 32'(mul_destReady), 32'h0);
        resp_ready = 4'b1000;
        #1 chk("t4_dest1", 32'(mul_destReady), 32'h1);
        tick();
        mul_outputReady = 1'b0;
        resp_ready = '0;
        chk("t4_inflight3", 32'(inflight), 32'h3);
        chk("t4_resume", 32'(mul_srcReady), 32'h1);
        tick();
        chk("t4_refill", 32'(inflight), 32'h4);
        chk("t4_src_off", 32'(mul_srcReady), 32'h0);
        mul_outputReady = 1'b1;
        mul_result = 16'h301;
        resp_ready = 4'hF;
        #1 chk("t4_head0", 32'(resp_valid), 32'h1);
        tick();
        mul_outputReady = 1'b0;
        chk("t4_inflight3b", 32'(inflight), 32'h3);

        // reset with three tags outstanding
        req_valid = 4'hF;
        rst = 1'b0;
        #1 chk("t5_req_ready", 32'(req_ready), 32'h0);
        chk("t5_srcReady", 32'(mul_srcReady), 32'h0);
        chk("t5_inflight", 32'(inflight), 32'h0);
        chk("t5_resp_valid", 32'(resp_valid), 32'h0);
        chk("t5_destReady", 32'(mul_destReady), 32'h0);
        chk("t5_err0", 32'(err_orphan), 32'h0);
        req_valid = '0;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mul_outputReady = 1'b1;
            mul_result = 16'hDEA0 + 16'(k);
            #1 chk("t5_orphan_valid", 32'(resp_valid), 32'h0);
            chk("t5_orphan_dest", 32'(mul_destReady), 32'h1);
            tick();
            chk("t5_err1", 32'(err_orphan), 32'h1);
        end
        mul_outputReady = 1'b0;
        tick();
        chk("t5_sticky", 32'(err_orphan), 32'h1);
        chk("t5_inflight0", 32'(inflight), 32'h0);
        rst = 1'b0;
        #1 rst = 1'b1;
        chk("t5_err_clear", 32'(err_orphan), 32'h0);

        // response stall
        resp_ready = '0;
        req_valid = 4'b0100;
        #1 chk("t6_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        tick();
        chk("t6_inflight1", 32'(inflight), 32'h1);
        mul_outputReady = 1'b1;
        mul_result = 16'h0ABC;
        for (int k = 0; k < 3; k++) begin
            #1 chk("t6_dest0", 32'(mul_destReady), 32'h0);
            chk("t6_hold", 32'(resp_data), 32'h0ABC);
            chk("t6_valid", 32'(resp_valid), 32'h4);
            tick();
            chk("t6_kept", 32'(inflight), 32'h1);
        end
        resp_ready = 4'b0100;
        #1 chk("t6_dest1", 32'(mul_destReady), 32'h1);
        tick();
        mul_outputReady = 1'b0;
        chk("t6_inflight0", 32'(inflight), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mul_stage_arbiter.md
# mul_stage_arbiter

- Shares one pipelined 16-bit multiplier stage (`srcReady`/`readyForInput` in, `outputReady`/`destReady` out) between `NUM_REQ` requesters.
- Arbitrates requests round-robin and registers the granted operand pair into a one-entry issue register.
- Records the requester ID of every operand pair the multiplier accepts in an in-order tag FIFO.
- Steers each multiplier result back to the requester at the FIFO head; sits between the neuron-update sequencers and the shared multiplier.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8).
- `DATA_W`, 16, operand/result width.
- `MAX_INFLIGHT`, 4, tag FIFO depth; must be ≥ multiplier pipeline depth for full throughput; power of two.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous active-low reset.
- `req_valid` input NUM_REQ: per-requester operand pair valid.
- `req_ready` output NUM_REQ: per-requester accept; at most one bit high.
- `req_a`, `req_b` input NUM_REQ*DATA_W: packed operands; requester i occupies bits [i*DATA_W +: DATA_W].
- `resp_valid` output NUM_REQ: result valid for requester i; at most one bit high.
- `resp_ready` input NUM_REQ: requester i can take its result.
- `resp_data` output DATA_W: result, shared by all requesters.
- `mul_srcReady` output 1, `mul_readyForInput` input 1: issue handshake to the multiplier.
- `mul_in_A`, `mul_in_B` output DATA_W: operands to the multiplier.
- `mul_outputReady` input 1, `mul_destReady` output 1, `mul_result` input DATA_W: result handshake from the multiplier.
- `inflight` output $clog2(MAX_INFLIGHT)+1: tag FIFO occupancy.
- `err_orphan` output 1: sticky flag for a result that arrives with no outstanding tag.

## Operation
- Transfer rules:
  - A request transfers when `req_valid[i] & req_ready[i]` at a clock edge.
  - Issue completes when `mul_srcReady & mul_readyForInput`.
  - A result transfers when `mul_outputReady & mul_destReady`.
- Issue register: holds {A, B, tag} plus a `full` bit.
  - `mul_srcReady = full & (inflight < MAX_INFLIGHT)`.
  - Contents must not change while `mul_srcReady` is high and not accepted.
- Grant:
  - `req_ready[g]` is high only when `g` is the round-robin winner and the issue register is empty or issuing this cycle.
  - The winner is the first `req_valid` bit searched from `rr_ptr` upward, wrapping at NUM_REQ.
  - On a request transfer, `rr_ptr <= g+1 mod NUM_REQ`. `rr_ptr` is unchanged if there is no transfer.
- Tag FIFO: push `tag` on issue; pop on result transfer. `inflight` counts entries.
  - Simultaneous push and pop leaves the count unchanged.
  - Push is impossible at full, because issue is gated by `inflight < MAX_INFLIGHT` (registered count).
- Result steering with FIFO non-empty, head tag h:
  - `resp_valid[h] = mul_outputReady`.
  - `resp_data = mul_result`.
  - `mul_destReady = resp_ready[h]`.
- Orphan result: `mul_outputReady` with FIFO empty.
  - Set `err_orphan`; drive `mul_destReady=1` to drain the result; all `resp_valid` stay 0.
  - Only reset clears `err_orphan`.
- Reset (async, `rst`=0) clears:
  - issue register `full` and `rr_ptr` to 0;
  - FIFO pointers, so `inflight`=0;
  - `err_orphan`.
  - Reset during operation drops all in-flight tags. Results already inside the multiplier are then treated as orphans.

## Timing
Output reset values:
- `req_ready` 0, `resp_valid` 0, `mul_srcReady` 0, `mul_destReady` 0.
- `mul_in_A`, `mul_in_B`, `resp_data` are don't-care (registers reset to 0).
- `inflight` 0, `err_orphan` 0.

Latency and throughput:
- Request transfer at edge T gives `mul_srcReady` high in cycle T+1.
- Result to response is combinational (0 cycles).
- Full throughput is one request per cycle while the multiplier accepts and `inflight < MAX_INFLIGHT`.
- `req_ready`, `resp_valid`, and `mul_destReady` are combinational from registered state and current inputs. There are no combinational paths from `mul_readyForInput` to `mul_destReady`.

## Structure
- `mul_arb_pkg` holds: `DATA_W` default, the tag type `logic [$clog2(NUM_REQ)-1:0]`, and the round-robin next-index function.
- Sub-module `mul_tag_fifo`: synchronous FIFO of tags with push, pop, count, full, and empty. Depth `MAX_INFLIGHT`, wrap-around read/write pointers, async active-low reset.
- Top level: arbiter, issue register, steering logic, orphan flag.

## Test plan
1. Single requester: req 1 sends A=0x3C00, B=0x4000; the multiplier model returns 0x4000. Expect `mul_srcReady` at T+1, `resp_valid[1]`=1 with `resp_data`=0x4000, and `inflight` going 1 then 0.
2. Round-robin: all 4 requesters are valid continuously and the multiplier is always ready. Grants run 0,1,2,3,0,…; results return in the same order, each tagged to the correct requester.
3. Backpressure: `mul_readyForInput`=0 for 5 cycles with the issue register full. Operands stay stable, no `req_ready`, `inflight` unchanged; issue occurs on the cycle `mul_readyForInput` rises.
4. FIFO full: `MAX_INFLIGHT`=4 with `resp_ready`=0. After 4 issues, `mul_srcReady` drops and `inflight`=4. Raising `resp_ready[h]` pops one entry and issue resumes the following cycle.
5. Reset mid-flight: assert `rst`=0 with 3 entries in flight. All outputs return to their reset values immediately. The multiplier model then emits 3 stale results: `err_orphan`=1, `mul_destReady`=1, no `resp_valid`.
6. Response stall: `resp_ready[h]`=0 for 3 cycles while `mul_outputReady`=1. `mul_destReady`=0 and `resp_data` is held; the result is released on the first cycle `resp_ready[h]`=1.
